// File: rtl/config_bus_pkg.sv
// config_bus_pkg
//   Shared definitions for the configuration register bus masters:
//   bus/address widths, the access-sequencer state encoding and a helper
//   that sizes requester index fields (never narrower than one bit).
package config_bus_pkg;

  localparam int CONFIG_BUS_WIDTH  = 32;
  localparam int CONFIG_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } cb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/config_bus_arbiter_if.sv
// config_bus_arbiter_if
//   Requester-side handshake of the configuration bus arbiter.
//   req_valid/req_we : per-requester request and direction (1 = write)
//   req_addr/req_wdata : flattened, requester i at bits [32i+31:32i]
//   req_ack   : one-cycle completion pulse per requester
//   req_rdata : data of the last completed read, shared by all requesters
//   modport master : requester side; modport slave : arbiter side
interface config_bus_arbiter_if
  import config_bus_pkg::*;
#(
  parameter int NUM_REQUESTERS = 2
);

  logic [NUM_REQUESTERS-1:0]                   req_valid;
  logic [NUM_REQUESTERS-1:0]                   req_we;
  logic [NUM_REQUESTERS*CONFIG_ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQUESTERS*CONFIG_BUS_WIDTH-1:0]  req_wdata;
  logic [NUM_REQUESTERS-1:0]                   req_ack;
  logic [CONFIG_BUS_WIDTH-1:0]                 req_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ack, req_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ack, req_rdata
  );

endinterface

// File: rtl/config_bus_arbiter_rr.sv
// round_robin_arbiter
//   Purely combinational round-robin pick. The search starts one above
//   last_grant and wraps modulo NUM_REQUESTERS, so the last winner has the
//   lowest priority on the next decision.
//   req         : request vector
//   last_grant  : index of the previous winner
//   grant       : one-hot winner (all zero when nothing requests)
//   grant_idx   : binary index of the winner
//   grant_valid : at least one request present
module round_robin_arbiter
  import config_bus_pkg::*;
#(
  parameter  int NUM_REQUESTERS = 2,
  localparam int IDX_W          = idx_width(NUM_REQUESTERS)
) (
  input  logic [NUM_REQUESTERS-1:0] req,
  input  logic [IDX_W-1:0]          last_grant,
  output logic [NUM_REQUESTERS-1:0] grant,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      grant_valid
);

  always_comb begin
    int cand;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    for (int off = 1; off <= NUM_REQUESTERS; off++) begin
      cand = (int'(last_grant) + off) % NUM_REQUESTERS;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/config_bus_arbiter.sv
// config_bus_arbiter
//   Shares the configuration register bus between NUM_REQUESTERS masters.
//   One access at a time, round-robin, sequenced IDLE -> SETUP -> ACCESS
//   -> DONE (strobe in the third cycle, ack in the fourth).
//   clk, rst    : clock, synchronous active-high reset
//   req_if      : requester handshake (slave modport)
//   bus_we      : registered write strobe (ACCESS of a write)
//   bus_oe      : registered read enable  (ACCESS of a read)
//   bus_address : last latched address, held between accesses
//   bus_data    : driven in SETUP and ACCESS of a write, Z otherwise
//   busy        : FSM not in IDLE
module config_bus_arbiter
  import config_bus_pkg::*;
#(
  parameter int NUM_REQUESTERS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  config_bus_arbiter_if.slave          req_if,
  output logic                         bus_we,
  output logic                         bus_oe,
  output logic [CONFIG_ADDR_WIDTH-1:0] bus_address,
  inout  wire  [CONFIG_BUS_WIDTH-1:0]  bus_data,
  output logic                         busy
);

  localparam int IDX_W = idx_width(NUM_REQUESTERS);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_SETUP  = SETUP;
  localparam logic [1:0] S_ACCESS = ACCESS;
  localparam logic [1:0] S_DONE   = DONE;

  // Pointing at the highest index makes requester 0 the first winner.
  localparam logic [IDX_W-1:0] LAST_GRANT_RST = IDX_W'(NUM_REQUESTERS - 1);

  logic [1:0]                   state_q, state_d;
  logic [IDX_W-1:0]             gnt_q, gnt_d;
  logic [IDX_W-1:0]             last_grant_q, last_grant_d;
  logic [CONFIG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                         we_q, we_d;
  logic [CONFIG_BUS_WIDTH-1:0]  wdata_q, wdata_d;
  logic [CONFIG_BUS_WIDTH-1:0]  rdata_q, rdata_d;
  logic [NUM_REQUESTERS-1:0]    ack_q, ack_d;
  logic                         bus_we_q, bus_we_d;
  logic                         bus_oe_q, bus_oe_d;
  logic                         drive_q, drive_d;

  logic [NUM_REQUESTERS-1:0]    rr_grant;
  logic [IDX_W-1:0]             rr_idx;
  logic                         rr_valid;

  logic                         sel_we;
  logic [CONFIG_ADDR_WIDTH-1:0] sel_addr;
  logic [CONFIG_BUS_WIDTH-1:0]  sel_wdata;

  round_robin_arbiter #(
    .NUM_REQUESTERS (NUM_REQUESTERS)
  ) u_rr (
    .req         (req_if.req_valid),
    .last_grant  (last_grant_q),
    .grant       (rr_grant),
    .grant_idx   (rr_idx),
    .grant_valid (rr_valid)
  );

  // AND-OR mux of the winner's fields, driven by the one-hot grant.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (rr_grant[i]) begin
        sel_we    = req_if.req_we[i];
        sel_addr  = req_if.req_addr[i*CONFIG_ADDR_WIDTH +: CONFIG_ADDR_WIDTH];
        sel_wdata = req_if.req_wdata[i*CONFIG_BUS_WIDTH +: CONFIG_BUS_WIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;

    case (state_q)
      S_IDLE: begin
        // Request fields are captured only here; later changes are ignored.
        if (rr_valid) begin
          state_d      = S_SETUP;
          gnt_d        = rr_idx;
          last_grant_d = rr_idx;
          addr_d       = sel_addr;
          we_d         = sel_we;
          wdata_d      = sel_wdata;
        end
      end
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        state_d = S_DONE;
        if (!we_q) rdata_d = bus_data;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state so the registered outputs
    // line up exactly with the state they belong to; we and oe come from
    // one direction bit and cannot overlap.
    bus_we_d = (state_d == S_ACCESS) &&  we_d;
    bus_oe_d = (state_d == S_ACCESS) && !we_d;
    drive_d  = ((state_d == S_SETUP) || (state_d == S_ACCESS)) && we_d;
    for (int i = 0; i < NUM_REQUESTERS; i++)
      ack_d[i] = (state_d == S_DONE) && (gnt_d == IDX_W'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      last_grant_q <= LAST_GRANT_RST;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      ack_q        <= '0;
      bus_we_q     <= 1'b0;
      bus_oe_q     <= 1'b0;
      drive_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
      bus_we_q     <= bus_we_d;
      bus_oe_q     <= bus_oe_d;
      drive_q      <= drive_d;
    end
  end

  assign bus_we           = bus_we_q;
  assign bus_oe           = bus_oe_q;
  assign bus_address      = addr_q;
  assign bus_data         = drive_q ? wdata_q : {CONFIG_BUS_WIDTH{1'bz}};
  assign busy             = (state_q != S_IDLE);
  assign req_if.req_ack   = ack_q;
  assign req_if.req_rdata = rdata_q;

endmodule

// File: tb/tb_config_bus_arbiter.sv
// tb_config_bus_arbiter
//   Directed bench: a 2-requester arbiter on a bus with a small register
//   model, plus a 3-requester arbiter for the wrap-around priority case.
module tb_config_bus_arbiter;
  import config_bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // 2-requester instance with a register model on its bus
  config_bus_arbiter_if #(.NUM_REQUESTERS(2)) rif ();
  logic        bus_we, bus_oe, busy;
  logic [31:0] bus_address;
  wire  [31:0] bus_data;

  logic [31:0] regmem [0:255];
  logic        probe_en  = 1'b0;
  logic [31:0] probe_val = 32'h1234_5678;

  assign bus_data = bus_oe   ? regmem[bus_address[7:0]] :
                    probe_en ? probe_val : 32'bz;

  always @(posedge clk) if (bus_we) regmem[bus_address[7:0]] <= bus_data;

  config_bus_arbiter #(.NUM_REQUESTERS(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_if      (rif),
    .bus_we      (bus_we),
    .bus_oe      (bus_oe),
    .bus_address (bus_address),
    .bus_data    (bus_data),
    .busy        (busy)
  );

  // 3-requester instance, writes only
  config_bus_arbiter_if #(.NUM_REQUESTERS(3)) rif3 ();
  logic        bus_we3, bus_oe3, busy3;
  logic [31:0] bus_address3;
  wire  [31:0] bus_data3;

  config_bus_arbiter #(.NUM_REQUESTERS(3)) dut3 (
    .clk         (clk),
    .rst         (rst),
    .req_if      (rif3),
    .bus_we      (bus_we3),
    .bus_oe      (bus_oe3),
    .bus_address (bus_address3),
    .bus_data    (bus_data3),
    .busy        (busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // we and oe must never overlap on either bus
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      assert (!((bus_we && bus_oe) || (bus_we3 && bus_oe3))) else begin
        bad++;
        $error("FAIL we_oe_excl: observed=1 expected=0");
      end
    end
  end

  initial begin
    rif.req_valid  = '0;  rif.req_we    = '0;
    rif.req_addr   = '0;  rif.req_wdata = '0;
    rif3.req_valid = '0;  rif3.req_we   = '0;
    rif3.req_addr  = '0;  rif3.req_wdata = '0;

    // ---------------- reset state ----------------
    tick(2);
    rst = 1'b0;
    chk("rst_ack",    32'(rif.req_ack), 32'h0);
    chk("rst_we",     32'(bus_we),      32'h0);
    chk("rst_oe",     32'(bus_oe),      32'h0);
    chk("rst_addr",   bus_address,      32'h0);
    chk("rst_busy",   32'(busy),        32'h0);
    chk("rst_rdata",  rif.req_rdata,    32'h0);

    // ---------------- single write, requester 0 ----------------
    rif.req_valid[0]    = 1'b1;
    rif.req_we[0]       = 1'b1;
    rif.req_addr[31:0]  = 32'h10;
    rif.req_wdata[31:0] = 32'hDEAD_BEEF;
    tick();                                   // cycle 1 SETUP
    chk("wr_c1_busy", 32'(busy),       32'h1);
    chk("wr_c1_we",   32'(bus_we),     32'h0);
    chk("wr_c1_addr", bus_address,     32'h10);
    chk("wr_c1_data", bus_data,        32'hDEAD_BEEF);
    tick();                                   // cycle 2 ACCESS
    chk("wr_c2_we",   32'(bus_we),     32'h1);
    chk("wr_c2_data", bus_data,        32'hDEAD_BEEF);
    chk("wr_c2_ack",  32'(rif.req_ack), 32'h0);
    tick();                                   // cycle 3 DONE
    chk("wr_c3_we",   32'(bus_we),     32'h0);
    chk("wr_c3_ack",  32'(rif.req_ack), 32'h1);
    rif.req_valid[0] = 1'b0;
    tick();                                   // cycle 4 IDLE
    chk("wr_c4_ack",  32'(rif.req_ack), 32'h0);
    chk("wr_c4_busy", 32'(busy),       32'h0);
    chk("wr_reg10",   regmem[8'h10],   32'hDEAD_BEEF);

    // ---------------- single read, requester 1 ----------------
    rif.req_valid[1]    = 1'b1;
    rif.req_we[1]       = 1'b0;
    rif.req_addr[63:32] = 32'h10;
    tick();
    chk("rd_c1_oe",   32'(bus_oe),     32'h0);
    chk("rd_c1_we",   32'(bus_we),     32'h0);
    tick();
    chk("rd_c2_oe",   32'(bus_oe),     32'h1);
    chk("rd_c2_we",   32'(bus_we),     32'h0);
    tick();
    chk("rd_c3_oe",   32'(bus_oe),     32'h0);
    chk("rd_c3_ack",  32'(rif.req_ack), 32'h2);
    chk("rd_c3_data", rif.req_rdata,   32'hDEAD_BEEF);
    rif.req_valid[1] = 1'b0;
    tick();

    // ---------------- contention from reset ----------------
    rst = 1'b1;
    rif.req_valid       = 2'b11;
    rif.req_we          = 2'b11;
    rif.req_addr        = {32'h24, 32'h20};
    rif.req_wdata       = {32'h0000_5A5A, 32'hA5A5_0000};
    tick();
    rst = 1'b0;                               // cycle 0 of contention
    chk("ct_rdata_rst", rif.req_rdata, 32'h0);
    for (int c = 1; c <= 15; c++) begin
      tick();
      chk($sformatf("ct_ack_c%0d", c), 32'(rif.req_ack),
          (c % 4 != 3) ? 32'h0 : (((c / 4) % 2 == 0) ? 32'h1 : 32'h2));
    end
    rif.req_valid = 2'b00;
    tick();                                   // cycle 16 IDLE
    chk("ct_busy_end", 32'(busy),      32'h0);
    chk("ct_reg20",    regmem[8'h20],  32'hA5A5_0000);
    chk("ct_reg24",    regmem[8'h24],  32'h0000_5A5A);
    chk("ct_rdata_hold", rif.req_rdata, 32'h0);

    // ---------------- valid dropped, fields changed ----------------
    rif.req_valid[0]    = 1'b1;
    rif.req_we[0]       = 1'b1;
    rif.req_addr[31:0]  = 32'h30;
    rif.req_wdata[31:0] = 32'h1111_2222;
    tick();                                   // cycle 1
    rif.req_valid[0]    = 1'b0;
    rif.req_addr[31:0]  = 32'h99;
    rif.req_wdata[31:0] = 32'hFFFF_FFFF;
    chk("vd_c1_addr", bus_address,     32'h30);
    tick();
    chk("vd_c2_we",   32'(bus_we),     32'h1);
    chk("vd_c2_addr", bus_address,     32'h30);
    chk("vd_c2_data", bus_data,        32'h1111_2222);
    tick();
    chk("vd_c3_ack",  32'(rif.req_ack), 32'h1);
    tick();
    chk("vd_c4_ack",  32'(rif.req_ack), 32'h0);
    chk("vd_reg30",   regmem[8'h30],   32'h1111_2222);

    // ---------------- reset during ACCESS of a write ----------------
    rif.req_valid[0]    = 1'b1;
    rif.req_addr[31:0]  = 32'h40;
    rif.req_wdata[31:0] = 32'hCAFE_F00D;
    tick(2);                                  // cycle 2 ACCESS
    chk("ab_c2_we",   32'(bus_we),     32'h1);
    rst = 1'b1;
    // both requesters pending once reset lifts; 0 must win after pointer reset
    rif.req_valid       = 2'b11;
    rif.req_we          = 2'b01;
    rif.req_addr        = {32'h10, 32'h50};
    rif.req_wdata[31:0] = 32'h5050_5050;
    tick();
    rst = 1'b0;
    chk("ab_we",      32'(bus_we),     32'h0);
    chk("ab_oe",      32'(bus_oe),     32'h0);
    chk("ab_ack",     32'(rif.req_ack), 32'h0);
    chk("ab_busy",    32'(busy),       32'h0);
    chk("ab_rdata",   rif.req_rdata,   32'h0);
    probe_en = 1'b1;
    #1;
    chk("ab_data_z",  bus_data,        32'h1234_5678);
    probe_en = 1'b0;
    tick(3);
    chk("ab_next0_ack", 32'(rif.req_ack), 32'h1);
    rif.req_valid[0] = 1'b0;
    tick(4);
    chk("ab_next1_ack", 32'(rif.req_ack), 32'h2);
    chk("ab_next1_rd",  rif.req_rdata,    32'hDEAD_BEEF);
    rif.req_valid[1] = 1'b0;
    tick();
    chk("ab_reg50",   regmem[8'h50],   32'h5050_5050);

    // ---------------- 3 requesters: wrap from last grant 0 ----------------
    rif3.req_valid[0]     = 1'b1;
    rif3.req_we           = 3'b111;
    rif3.req_addr         = {32'h8, 32'h6, 32'h4};
    rif3.req_wdata        = {32'h3, 32'h2, 32'h1};
    tick(3);
    chk("n3_first_ack",  32'(rif3.req_ack), 32'h1);
    rif3.req_valid[2] = 1'b1;
    tick(4);
    chk("n3_second_ack", 32'(rif3.req_ack), 32'h4);
    chk("n3_second_addr", bus_address3,     32'h8);
    tick(4);
    chk("n3_third_ack",  32'(rif3.req_ack), 32'h1);
    rif3.req_valid = '0;
    tick(2);
    chk("n3_idle",       32'(busy3),        32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
